// File: rtl/fft_bin_serializer_pkg.sv
// Shared constants and state encoding for the FFT bin serializer.
// Word width follows the FFT datapath: W = 2**N bits per component.
package fft_bin_serializer_pkg;

    localparam int N_DEF = 4;
    localparam int W     = 2 ** N_DEF;
    localparam int BINS  = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Two's-complement negate; the most-negative value wraps to itself.
    function automatic logic [W-1:0] conj_neg(input logic [W-1:0] x);
        return W'(0) - x;
    endfunction

endpackage

// File: rtl/fft_bin_serializer.sv
// Captures one parallel 8-bin FFT frame and streams it out one bin per beat,
// optionally conjugated, with a back-to-back refill on the last beat.
module fft_bin_serializer
    import fft_bin_serializer_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_conj,
    input  logic [BINS*(2**N)-1:0]   in_re,
    input  logic [BINS*(2**N)-1:0]   in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [(2**N)-1:0]        out_re,
    output logic [(2**N)-1:0]        out_im,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last
);

    localparam int WD = 2 ** N;

    state_t state;
    state_t state_next;

    logic [WD-1:0]    re_q [BINS];
    logic [WD-1:0]    im_q [BINS];
    logic [IDX_W-1:0] idx;
    logic             conj;

    logic stream;
    logic at_last;
    logic capture;
    logic beat;

    assign stream   = (state == STREAM);
    assign at_last  = (idx == IDX_W'(BINS - 1));
    assign in_ready = !stream || (at_last && out_ready);
    assign capture  = in_valid && in_ready;
    assign beat     = stream && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A capture on the last beat keeps the FSM in STREAM with no bubble.
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_re     = '0;
        out_im     = '0;
        out_idx    = '0;
        out_last   = 1'b0;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                out_re    = re_q[idx];
                out_im    = conj ? (WD'(0) - im_q[idx]) : im_q[idx];
                out_idx   = idx;
                out_last  = at_last;
                if (beat && at_last && !capture) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Imaginary parts of the DC and Nyquist bins are zero by construction.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            conj <= 1'b0;
            for (int k = 0; k < BINS; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else if (capture) begin
            idx  <= '0;
            conj <= in_conj;
            for (int k = 0; k < BINS; k++) begin
                re_q[k] <= in_re[k*WD +: WD];
                if (k == 0 || k == BINS / 2) begin
                    im_q[k] <= '0;
                end else begin
                    im_q[k] <= in_im[k*WD +: WD];
                end
            end
        end else if (beat && !at_last) begin
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Randomized self-checking bench for fft_bin_serializer with a queue-based
// scoreboard of expected bins derived from each accepted frame.
module tb_fft_bin_serializer;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_conj;
    logic [8*W-1:0] in_re;
    logic [8*W-1:0] in_im;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_re;
    logic [W-1:0]   out_im;
    logic [2:0]     out_idx;
    logic           out_last;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [2:0]   idx;
    } beat_t;

    beat_t q[$];

    fft_bin_serializer #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_conj   (in_conj),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // dmode 0: re=k+1, im=16k; 1: random; 2: random with im[1]=0x8000
    task automatic load_frame(input int dmode, input bit conj);
        for (int k = 0; k < 8; k++) begin
            if (dmode == 0) begin
                in_re[k*W +: W] = 16'(k + 1);
                in_im[k*W +: W] = 16'(16 * k);
            end else begin
                in_re[k*W +: W] = 16'($urandom);
                in_im[k*W +: W] = 16'($urandom);
            end
        end
        if (dmode == 2) in_im[1*W +: W] = 16'h8000;
        in_conj = conj;
    endtask

    task automatic push_frame();
        beat_t b;
        logic [W-1:0] raw;
        for (int k = 0; k < 8; k++) begin
            raw   = in_im[k*W +: W];
            b.re  = in_re[k*W +: W];
            b.idx = 3'(k);
            if (k == 0 || k == 4) b.im = '0;
            else if (in_conj)     b.im = 16'(-int'($signed(raw)));
            else                  b.im = raw;
            q.push_back(b);
        end
    endtask

    // rmode 0: always ready; 1: ready on every third cycle; 2: random.
    task automatic run(input int nf, input int rmode, input int dmode,
                       input int cmode, input string tag, output int gaps);
        int    sent  = 0;
        int    beats = 0;
        int    cyc   = 0;
        bit    started = 0;
        bit    stalled = 0;
        bit    acc;
        beat_t e;
        logic [W-1:0] p_re, p_im;
        logic [2:0]   p_idx;
        gaps     = 0;
        in_valid = 1'b0;
        while (beats < nf * 8 && cyc < 3000) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (!in_valid && sent < nf) begin
                load_frame(dmode, cmode == 2 ? 1'($urandom_range(0, 1)) : 1'(cmode));
                in_valid = 1'b1;
            end
            #1;
            total++;
            if (out_valid !== (q.size() != 0)) begin
                $display("FAIL %s out_valid: got %b want %b", tag, out_valid, q.size() != 0);
            end else passed++;
            total++;
            if (in_ready !== (q.size() == 0 || (q.size() == 1 && out_ready))) begin
                $display("FAIL %s in_ready: got %b want %b (pending %0d)", tag, in_ready,
                         q.size() == 0 || (q.size() == 1 && out_ready), q.size());
            end else passed++;
            if (out_valid) begin
                started = 1;
                if (stalled) begin
                    total++;
                    if (out_re !== p_re || out_im !== p_im || out_idx !== p_idx) begin
                        $display("FAIL %s stall_hold: got %h/%h/%0d want %h/%h/%0d",
                                 tag, out_re, out_im, out_idx, p_re, p_im, p_idx);
                    end else passed++;
                end
                if (out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        $display("FAIL %s extra_beat: got idx %0d want none", tag, out_idx);
                    end else begin
                        e = q.pop_front();
                        total++;
                        if (out_idx !== e.idx) begin
                            $display("FAIL %s idx: got %0d want %0d", tag, out_idx, e.idx);
                        end else passed++;
                        total++;
                        if (out_re !== e.re) begin
                            $display("FAIL %s re[%0d]: got %h want %h", tag, e.idx, out_re, e.re);
                        end else passed++;
                        total++;
                        if (out_im !== e.im) begin
                            $display("FAIL %s im[%0d]: got %h want %h", tag, e.idx, out_im, e.im);
                        end else passed++;
                        total++;
                        if (out_last !== (e.idx == 3'd7)) begin
                            $display("FAIL %s last[%0d]: got %b want %b", tag, e.idx,
                                     out_last, e.idx == 3'd7);
                        end else passed++;
                        if (dmode == 2 && in_conj == 1'b1 && e.idx == 3'd1) begin
                            total++;
                            if (out_im !== 16'h8000) begin
                                $display("FAIL %s wrap: got %h want 8000", tag, out_im);
                            end else passed++;
                        end
                    end
                    beats++;
                end
                stalled = !out_ready;
                p_re    = out_re;
                p_im    = out_im;
                p_idx   = out_idx;
            end else begin
                stalled = 0;
                if (started) gaps++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                push_frame();
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        total++;
        if (cyc >= 3000) begin
            $display("FAIL %s timeout: got %0d beats want %0d", tag, beats, nf * 8);
        end else passed++;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_conj   = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_idx !== 3'd0 ||
            out_re !== 16'd0 || out_im !== 16'd0) begin
            $display("FAIL reset_outputs: got v%b l%b i%0d %h/%h want all zero",
                     out_valid, out_last, out_idx, out_re, out_im);
        end else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int g;
        run(1, 0, 0, 0, "single", g);
        run(1, 0, 0, 1, "single_conj", g);
    endtask

    task automatic test_backpressure();
        int g;
        run(2, 1, 1, 2, "bp_pattern", g);
        run(3, 2, 1, 2, "bp_random", g);
    endtask

    task automatic test_back_to_back();
        int g;
        run(2, 0, 1, 0, "b2b", g);
        total++;
        if (g !== 0) begin
            $display("FAIL b2b_gap: got %0d idle cycles want 0", g);
        end else passed++;
        run(4, 2, 1, 2, "b2b_rand", g);
        total++;
        if (g !== 0) begin
            $display("FAIL b2b_rand_gap: got %0d idle cycles want 0", g);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        int g;
        int n = 0;
        out_ready = 1'b1;
        load_frame(1, 0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (out_idx !== 3'd3 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (out_idx !== 3'd3 || out_valid !== 1'b1) begin
            $display("FAIL mid_reach_idx3: got v%b idx %0d want v1 idx 3", out_valid, out_idx);
        end else passed++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0) begin
            $display("FAIL mid_reset: got v%b r%b idx %0d want v0 r1 idx 0",
                     out_valid, in_ready, out_idx);
        end else passed++;
        q.delete();
        run(1, 0, 1, 2, "after_rst", g);
    endtask

    task automatic test_wrap();
        int g;
        run(1, 0, 2, 1, "wrap", g);
        run(1, 2, 2, 1, "wrap_bp", g);
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fft_bin_serializer.md
Name: fft_bin_serializer

Overview:
- Consumer-side companion to the 8-point radix-2 FFT final stage.
- Captures one parallel frame of the eight final-stage output bins in a single cycle.
- Streams the frame out one complex bin per beat, in natural order k=0..7, over a valid/ready handshake.
- Supplies downstream logic (magnitude, UART/readback, IFFT feed) with a serial, back-pressurable bin stream. Optional per-frame conjugation lets the same path feed an inverse transform.

Parameters:
- N, 4, word-width exponent; every data word is 2**N bits (two's complement), matching the FFT datapath.
- BINS, 8, bins per frame; fixed at 8, and the index width is 3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a parallel frame is presented.
- in_ready  output  1  serializer accepts the frame this cycle.
- in_conj  input  1  sampled with the frame; 1 = output the conjugate (negated imaginary).
- in_re  input  8*(2**N)  real parts; bin k at [k*W +: W], W=2**N.
- in_im  input  8*(2**N)  imaginary parts; bins 0 and 4 are ignored and treated as 0.
- out_valid  output  1  a bin is presented.
- out_ready  input  1  downstream accepts the bin.
- out_re  output  2**N  real part of the current bin.
- out_im  output  2**N  imaginary part of the current bin.
- out_idx  output  3  bin index k of the current beat.
- out_last  output  1  high on the beat where out_idx==7.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high, sampled on the rising edge.
- Reset values: state=IDLE, out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0, frame buffer cleared, conj flag=0.
- in_ready in reset: reads 1 once reset is released (combinational from IDLE).
- Frame buffer: 8 real and 8 imaginary registers, plus a 3-bit index counter and a conj flag.
- Capture: on in_valid && in_ready, register all of in_re, force imag[0] and imag[4] to 0, register in_im for the other bins, latch in_conj.
- FSM state IDLE:
  - in_ready=1, out_valid=0.
  - On capture: idx<=0, go to STREAM.
- FSM state STREAM:
  - out_valid=1; out_re=re[idx].
  - out_im = conj ? -im[idx] : im[idx], negated in two's complement. Negating the most-negative value wraps to itself; no saturation.
  - On out_valid && out_ready with idx<7: idx<=idx+1.
  - On out_valid && out_ready with idx==7: return to IDLE, unless a new frame is captured in the same cycle.
- in_ready: in_ready = (state==IDLE) || (state==STREAM && idx==7 && out_ready). This allows back-to-back frames with no bubble.
- Simultaneous last-beat accept and new capture: the new frame overwrites the buffer, idx<=0, and the FSM stays in STREAM. The next cycle presents bin 0 of the new frame.
- Latency: a frame captured at edge T makes bin 0 visible with out_valid=1 after edge T. Each further bin needs one accepted beat.
- Throughput: one bin per cycle under out_ready=1. The steady state is 8 cycles per frame.
- Backpressure: while out_valid && !out_ready, out_re, out_im, out_idx and out_last hold stable. in_valid is ignored in STREAM except on the last-beat accept cycle.
- Source side: in_valid without in_ready is legal. The source must hold the frame until accepted.
- Reset mid-frame: aborts the frame; the remaining bins are dropped and never emitted.
- Output timing: outputs are a registered-state function. out_re/out_im may be a mux off the buffer, but must not depend combinationally on out_ready.

Decomposition:
- Shared package/header: word width W=2**N, BINS=8, index width 3, and the state encodings IDLE=0 and STREAM=1.
- No sub-module is needed. The conjugating negate may be a small function in the shared package, reused by future IFFT blocks.

Test Plan:
- Single frame, out_ready=1, in_re bin k = k+1, in_im bin k = 16*k, in_conj=0:
  - 8 beats, idx 0..7.
  - re 1..8.
  - im 0,16,32,48,0,80,96,112 (bin 4 imag forced 0).
  - out_last only on idx 7; in_ready=0 on beats 0..6.
- Same frame with in_conj=1: im 0,-16,-32,-48,0,-80,-96,-112 (0xFFF0 etc. for W=16).
- Backpressure with out_ready toggled 1,0,0,1,...: each bin appears exactly once, outputs are stable while stalled, and the order is preserved.
- Back-to-back frames A then B with in_valid held high and out_ready=1:
  - Frame B is accepted on A's idx==7 beat.
  - 16 consecutive valid beats with no gap; B's bin 0 follows A's bin 7.
- rst asserted on the beat with idx=3:
  - Next cycle: out_valid=0, in_ready=1, out_idx=0.
  - A new frame then streams from bin 0.
- Edge value: in_im bin 1 = 0x8000 with in_conj=1 gives out_im 0x8000 (wrap).
